// File: rtl/hpi_pkg.sv
// Shared state type, HPI register selects and sizing helpers for the
// CY7C67200 HPI bus sequencer.
package hpi_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RECOVER  = 3'd5
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    function automatic int max_cycles(input int a, input int b, input int c,
                                      input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // A one-bit counter is still needed when every phase lasts a single cycle.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpi_rr_arbiter.sv
// Two-way round-robin arbiter; the remembered winner only moves when the
// sequencer actually accepts a grant.
module hpi_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_idx
);

    logic last_grant;

    // On a tie the master that did not win last time goes next.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_en && grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/hpi_bus_sequencer.sv
// Owns the CY7C67200 HPI pins: arbitrates two requesters, sequences the
// CS/RD/WR strobes and pulses the chip reset.
module hpi_bus_sequencer
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int RST_CYC     = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sw_rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        hpi_rst_n,
    output logic        busy
);

    localparam int MAX_CYC = max_cycles(SETUP_CYC, STROBE_CYC, HOLD_CYC,
                                        RECOVER_CYC, RST_CYC);
    localparam int CNT_W   = cnt_width(MAX_CYC);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_LAST   = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t STROBE_LAST  = cnt_t'(STROBE_CYC - 1);
    localparam cnt_t HOLD_LAST    = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t RECOVER_LAST = cnt_t'(RECOVER_CYC - 1);
    localparam cnt_t RST_LAST     = cnt_t'(RST_CYC - 1);

    hpi_state_t  state, nxt_state;
    cnt_t        cnt, nxt_cnt;
    logic        sw_pending, nxt_pending;
    logic        acc_idx, nxt_idx;
    logic        acc_we, nxt_we;
    logic [1:0]  acc_addr, nxt_addr;
    logic [15:0] acc_wdata, nxt_wdata;
    logic [15:0] cap_data, nxt_cap;

    logic        grant_en, grant_valid, grant_idx;

    logic        in_access, nxt_ack;
    logic        nxt_cs_n, nxt_rd_n, nxt_wr_n, nxt_oe;
    logic [15:0] nxt_data_out;
    logic        nxt_ack0, nxt_ack1;
    logic [15:0] nxt_rdata0, nxt_rdata1;

    hpi_rr_arbiter u_arb (
        .clk         (Clk),
        .rst         (Reset),
        .req0        (m0_req),
        .req1        (m1_req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Phase sequencing: each timed state counts up from zero and leaves on
    // its last cycle, so the counter is reloaded on every state change.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_pending = sw_pending | sw_rst;
        nxt_idx     = acc_idx;
        nxt_we      = acc_we;
        nxt_addr    = acc_addr;
        nxt_wdata   = acc_wdata;
        nxt_cap     = cap_data;
        grant_en    = 1'b0;

        case (state)
            ST_RST_HOLD: begin
                if (sw_rst) begin
                    nxt_cnt = '0;
                end else if (cnt == RST_LAST) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                grant_en = 1'b1;
                if (grant_valid) begin
                    nxt_state = ST_SETUP;
                    nxt_idx   = grant_idx;
                    nxt_we    = grant_idx ? m1_we    : m0_we;
                    nxt_addr  = grant_idx ? m1_addr  : m0_addr;
                    nxt_wdata = grant_idx ? m1_wdata : m0_wdata;
                end else if (nxt_pending) begin
                    nxt_state = ST_RST_HOLD;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) nxt_state = ST_STROBE;
                else                   nxt_cnt   = cnt + 1'b1;
            end
            ST_STROBE: begin
                if (cnt == STROBE_LAST) begin
                    nxt_cap   = hpi_data_in;
                    nxt_state = ST_HOLD;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) nxt_state = ST_RECOVER;
                else                  nxt_cnt   = cnt + 1'b1;
            end
            ST_RECOVER: begin
                // A chip reset requested during the access beats any waiting request.
                if (cnt == RECOVER_LAST) nxt_state = nxt_pending ? ST_RST_HOLD : ST_IDLE;
                else                     nxt_cnt   = cnt + 1'b1;
            end
            default: begin
                nxt_state = ST_RST_HOLD;
            end
        endcase

        if (nxt_state != state) nxt_cnt = '0;
        if (nxt_state == ST_RST_HOLD) nxt_pending = 1'b0;
    end

    // Pin values are derived from the upcoming state so every output is a flop.
    always_comb begin
        in_access    = (nxt_state == ST_SETUP) || (nxt_state == ST_STROBE) ||
                       (nxt_state == ST_HOLD);
        nxt_cs_n     = ~in_access;
        nxt_rd_n     = ~((nxt_state == ST_STROBE) && !nxt_we);
        nxt_wr_n     = ~((nxt_state == ST_STROBE) && nxt_we);
        nxt_oe       = in_access && nxt_we;
        nxt_data_out = nxt_oe ? nxt_wdata : 16'h0000;
        nxt_ack      = (nxt_state == ST_HOLD) && (nxt_cnt == HOLD_LAST);
        nxt_ack0     = nxt_ack && !nxt_idx;
        nxt_ack1     = nxt_ack && nxt_idx;
        nxt_rdata0   = (nxt_ack0 && !nxt_we) ? nxt_cap : m0_rdata;
        nxt_rdata1   = (nxt_ack1 && !nxt_we) ? nxt_cap : m1_rdata;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_RST_HOLD;
            cnt          <= '0;
            sw_pending   <= 1'b0;
            acc_idx      <= 1'b0;
            acc_we       <= 1'b0;
            acc_addr     <= HPI_DATA;
            acc_wdata    <= 16'h0000;
            cap_data     <= 16'h0000;
            hpi_cs_n     <= 1'b1;
            hpi_rd_n     <= 1'b1;
            hpi_wr_n     <= 1'b1;
            hpi_rst_n    <= 1'b0;
            hpi_data_oe  <= 1'b0;
            hpi_addr     <= HPI_DATA;
            hpi_data_out <= 16'h0000;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= 16'h0000;
            m1_rdata     <= 16'h0000;
            busy         <= 1'b1;
        end else begin
            state        <= nxt_state;
            cnt          <= nxt_cnt;
            sw_pending   <= nxt_pending;
            acc_idx      <= nxt_idx;
            acc_we       <= nxt_we;
            acc_addr     <= nxt_addr;
            acc_wdata    <= nxt_wdata;
            cap_data     <= nxt_cap;
            hpi_cs_n     <= nxt_cs_n;
            hpi_rd_n     <= nxt_rd_n;
            hpi_wr_n     <= nxt_wr_n;
            hpi_rst_n    <= (nxt_state != ST_RST_HOLD);
            hpi_data_oe  <= nxt_oe;
            hpi_addr     <= nxt_addr;
            hpi_data_out <= nxt_data_out;
            m0_ack       <= nxt_ack0;
            m1_ack       <= nxt_ack1;
            m0_rdata     <= nxt_rdata0;
            m1_rdata     <= nxt_rdata1;
            busy         <= (nxt_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Bench for hpi_bus_sequencer: directed scenarios followed by random traffic,
// all checked every cycle against an access-age reference model.
module tb_hpi_bus_sequencer;

    localparam int SETUP_CYC   = 1;
    localparam int STROBE_CYC  = 4;
    localparam int HOLD_CYC    = 1;
    localparam int RECOVER_CYC = 2;
    localparam int RST_CYC     = 16;
    localparam int ACK_AGE     = SETUP_CYC + STROBE_CYC + HOLD_CYC;
    localparam int END_AGE     = ACK_AGE + RECOVER_CYC;

    logic        Clk, Reset, sw_rst;
    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [1:0]  m0_addr, m1_addr, hpi_addr;
    logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [15:0] hpi_data_out, hpi_data_in;
    logic        hpi_data_oe, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n, busy;

    int total = 0;
    int bad   = 0;

    // Reference model: time left in chip reset, age of the running access
    // (0 = none, 1 = first cycle after the grant), and the latched request.
    int          rst_left, acc_age, win, last_win;
    bit          pend;
    logic        acc_we;
    logic [1:0]  addr_m;
    logic [15:0] wdata_m, cap_m;
    logic [15:0] rdata_m [2];

    hpi_bus_sequencer #(
        .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC),
        .RECOVER_CYC(RECOVER_CYC), .RST_CYC(RST_CYC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .sw_rst(sw_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_data_in(hpi_data_in), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
        .hpi_wr_n(hpi_wr_n), .hpi_rst_n(hpi_rst_n), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void modelReset();
        rst_left   = RST_CYC;
        acc_age    = 0;
        pend       = 1'b0;
        last_win   = 1;
        win        = 0;
        acc_we     = 1'b0;
        addr_m     = 2'd0;
        wdata_m    = 16'h0000;
        cap_m      = 16'h0000;
        rdata_m[0] = 16'h0000;
        rdata_m[1] = 16'h0000;
    endfunction

    function automatic void modelEdge();
        if (rst_left > 0) begin
            if (sw_rst) rst_left = RST_CYC;
            else        rst_left--;
        end else if (acc_age > 0) begin
            if (acc_age == SETUP_CYC + STROBE_CYC) cap_m = hpi_data_in;
            acc_age++;
            if (acc_age == ACK_AGE && !acc_we) rdata_m[win] = cap_m;
            pend = pend | sw_rst;
            if (acc_age > END_AGE) begin
                acc_age = 0;
                if (pend) begin
                    rst_left = RST_CYC;
                    pend     = 1'b0;
                end
            end
        end else begin
            pend = pend | sw_rst;
            if (m0_req || m1_req) begin
                if (m0_req && m1_req) win = 1 - last_win;
                else                  win = m1_req ? 1 : 0;
                last_win = win;
                acc_age  = 1;
                acc_we   = (win == 1) ? m1_we    : m0_we;
                addr_m   = (win == 1) ? m1_addr  : m0_addr;
                wdata_m  = (win == 1) ? m1_wdata : m0_wdata;
            end else if (pend) begin
                rst_left = RST_CYC;
                pend     = 1'b0;
            end
        end
    endfunction

    task automatic chk_bit(input string name, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", name, obs, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        bit in_acc, strobe, ack;
        in_acc = (acc_age >= 1) && (acc_age <= ACK_AGE);
        strobe = (acc_age > SETUP_CYC) && (acc_age <= SETUP_CYC + STROBE_CYC);
        ack    = (acc_age == ACK_AGE);
        chk_bit ({tag, ".cs_n"},     hpi_cs_n,     !in_acc);
        chk_bit ({tag, ".rd_n"},     hpi_rd_n,     !(strobe && !acc_we));
        chk_bit ({tag, ".wr_n"},     hpi_wr_n,     !(strobe && acc_we));
        chk_bit ({tag, ".oe"},       hpi_data_oe,  in_acc && acc_we);
        chk_word({tag, ".data_out"}, hpi_data_out, (in_acc && acc_we) ? wdata_m : 16'h0000);
        chk_word({tag, ".addr"},     16'(hpi_addr), 16'(addr_m));
        chk_bit ({tag, ".m0_ack"},   m0_ack,       ack && (win == 0));
        chk_bit ({tag, ".m1_ack"},   m1_ack,       ack && (win == 1));
        chk_word({tag, ".m0_rdata"}, m0_rdata,     rdata_m[0]);
        chk_word({tag, ".m1_rdata"}, m1_rdata,     rdata_m[1]);
        chk_bit ({tag, ".rst_n"},    hpi_rst_n,    rst_left == 0);
        chk_bit ({tag, ".busy"},     busy,         (rst_left > 0) || (acc_age > 0));
    endtask

    task automatic applyStimulus(input string tag);
        @(posedge Clk);
        if (Reset) modelReset();
        else       modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic waitAck(input int who, input int limit, input string tag, output int waited);
        waited = 0;
        do begin
            applyStimulus(tag);
            waited++;
        end while (!((who == 0) ? m0_ack : m1_ack) && waited < limit);
        chk_bit({tag, ".ack_seen"}, (who == 0) ? m0_ack : m1_ack, 1'b1);
    endtask

    initial begin
        int waited;
        int low_cnt;
        int cyc;
        int ack_t[$];
        int ack_w[$];

        Reset = 1'b1; sw_rst = 1'b0; hpi_data_in = 16'h0000;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 2'd0; m0_wdata = 16'h0000;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 2'd0; m1_wdata = 16'h0000;
        modelReset();
        repeat (3) applyStimulus("in_reset");

        // Chip reset pulse after system reset.
        Reset = 1'b0;
        low_cnt = 0;
        do begin
            applyStimulus("rst_release");
            low_cnt++;
        end while (!hpi_rst_n && low_cnt < 40);
        chk_word("rst_low_cycles", 16'(low_cnt), 16'(RST_CYC));
        chk_bit("busy_after_rst", busy, 1'b0);
        applyStimulus("idle");

        // m0 write.
        m0_we = 1'b1; m0_addr = 2'd2; m0_wdata = 16'h1234; m0_req = 1'b1;
        waitAck(0, 20, "m0_write", waited);
        chk_word("m0_write_latency", 16'(waited), 16'(ACK_AGE));
        m0_req = 1'b0;
        repeat (3) applyStimulus("m0_write_tail");

        // m1 read.
        hpi_data_in = 16'hBEEF;
        m1_we = 1'b0; m1_addr = 2'd0; m1_req = 1'b1;
        waitAck(1, 20, "m1_read", waited);
        chk_word("m1_read_latency", 16'(waited), 16'(ACK_AGE));
        chk_word("m1_rdata_beef", m1_rdata, 16'hBEEF);
        chk_word("m0_rdata_kept", m0_rdata, 16'h0000);
        m1_req = 1'b0; hpi_data_in = 16'h0000;
        repeat (3) applyStimulus("m1_read_tail");

        // Both masters request continuously.
        m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 16'h5A5A; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 2'd3; m1_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            hpi_data_in = 16'($urandom);
            applyStimulus("tie");
            if (m0_ack) begin ack_t.push_back(i); ack_w.push_back(0); end
            if (m1_ack) begin ack_t.push_back(i); ack_w.push_back(1); end
        end
        chk_word("tie_ack_count", 16'(ack_w.size()), 16'd3);
        if (ack_w.size() >= 3) begin
            chk_word("tie_winner0", 16'(ack_w[0]), 16'd0);
            chk_word("tie_winner1", 16'(ack_w[1]), 16'd1);
            chk_word("tie_winner2", 16'(ack_w[2]), 16'd0);
            chk_word("tie_spacing1", 16'(ack_t[1] - ack_t[0]), 16'(END_AGE + 1));
            chk_word("tie_spacing2", 16'(ack_t[2] - ack_t[1]), 16'(END_AGE + 1));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (12) applyStimulus("tie_drain");

        // sw_rst during an m0 write strobe with m1 waiting.
        m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 16'hA5C3; m0_req = 1'b1;
        repeat (3) applyStimulus("swrst_setup");
        sw_rst = 1'b1;
        m1_we = 1'b0; m1_addr = 2'd3; m1_req = 1'b1;
        applyStimulus("swrst_pulse");
        sw_rst = 1'b0;
        waitAck(0, 20, "swrst_m0", waited);
        m0_req = 1'b0;
        waitAck(1, 60, "swrst_m1", waited);
        chk_word("swrst_m1_delay", 16'(waited), 16'(RECOVER_CYC + RST_CYC + 1 + ACK_AGE));
        m1_req = 1'b0;
        repeat (3) applyStimulus("swrst_tail");

        // Reset asserted mid-strobe.
        m0_we = 1'b1; m0_addr = 2'd2; m0_wdata = 16'h0F0F; m0_req = 1'b1;
        repeat (3) applyStimulus("abort_setup");
        Reset = 1'b1;
        #1;
        chk_bit("abort_cs_n", hpi_cs_n, 1'b1);
        chk_bit("abort_wr_n", hpi_wr_n, 1'b1);
        chk_bit("abort_oe", hpi_data_oe, 1'b0);
        chk_bit("abort_rst_n", hpi_rst_n, 1'b0);
        chk_bit("abort_ack", m0_ack, 1'b0);
        modelReset();
        repeat (2) applyStimulus("abort_hold");
        Reset = 1'b0;
        waitAck(0, 60, "abort_retry", waited);
        chk_word("abort_retry_delay", 16'(waited), 16'(RST_CYC + ACK_AGE));
        m0_req = 1'b0;
        repeat (3) applyStimulus("abort_tail");

        // First tie after reset goes to m0; m1 withdraws before its grant.
        Reset = 1'b1;
        applyStimulus("tie_rst");
        Reset = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_wdata = 16'h7777;
        cyc = 0;
        do begin
            applyStimulus("first_tie");
            cyc++;
        end while (!(m0_ack || m1_ack) && cyc < 60);
        chk_bit("first_tie_m0", m0_ack, 1'b1);
        chk_bit("first_tie_not_m1", m1_ack, 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (12) applyStimulus("withdraw");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (m0_req && acc_age == ACK_AGE && win == 0) begin
                m0_req = 1'b0;
            end else if (!m0_req && $urandom_range(3) == 0) begin
                m0_we    = 1'($urandom_range(1));
                m0_addr  = 2'($urandom_range(3));
                m0_wdata = 16'($urandom);
                m0_req   = 1'b1;
            end else if (m0_req && !(acc_age > 0 && win == 0) && $urandom_range(31) == 0) begin
                m0_req = 1'b0;
            end
            if (m1_req && acc_age == ACK_AGE && win == 1) begin
                m1_req = 1'b0;
            end else if (!m1_req && $urandom_range(3) == 0) begin
                m1_we    = 1'($urandom_range(1));
                m1_addr  = 2'($urandom_range(3));
                m1_wdata = 16'($urandom);
                m1_req   = 1'b1;
            end else if (m1_req && !(acc_age > 0 && win == 1) && $urandom_range(31) == 0) begin
                m1_req = 1'b0;
            end
            sw_rst      = ($urandom_range(63) == 0);
            hpi_data_in = 16'($urandom);
            applyStimulus("random");
        end
        sw_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpi_bus_sequencer.md
Name: hpi_bus_sequencer

Overview:
- Owns the CY7C67200 HPI pin interface and shares it between two requesters.
  - Master 0: the Nios software PIO path.
  - Master 1: a hardware keycode poller.
- Generates timed CS/RD/WR strobe sequences, plus the chip reset pulse after system reset.
- Sits between the requesters and the OTG_* tri-state pad logic in the top level.

Parameters:
- SETUP_CYC, 1, cycles CS_N/addr/data are valid before the strobe (>=1)
- STROBE_CYC, 4, cycles RD_N or WR_N is held low (>=1)
- HOLD_CYC, 1, cycles CS_N/addr/data are held after the strobe rises (>=1)
- RECOVER_CYC, 2, cycles with CS_N high before the next access (>=1)
- RST_CYC, 16, cycles hpi_rst_n is held low after reset or sw_rst (>=1)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- sw_rst  in  1  one-cycle request to re-pulse the chip reset
- m0_req, m1_req  in  1  access request; held until ack
- m0_we, m1_we  in  1  1=write, 0=read
- m0_addr, m1_addr  in  2  HPI register select
- m0_wdata, m1_wdata  in  16  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  16  read data; updated only on a read ack
- hpi_addr  out  2  to OTG_ADDR
- hpi_data_out  out  16  pad drive value
- hpi_data_oe  out  1  pad output enable
- hpi_data_in  in  16  from OTG_DATA
- hpi_cs_n, hpi_rd_n, hpi_wr_n  out  1  chip strobes, active low
- hpi_rst_n  out  1  chip reset, active low
- busy  out  1  high in any state except IDLE

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high. All outputs are registered.
- While Reset is high:
  - cs_n, rd_n, wr_n = 1; rst_n = 0.
  - oe = 0; addr = 0; data_out = 0; acks = 0; rdata = 0; busy = 1.
  - State = RST_HOLD, counter cleared, last_grant = 1.
- States: RST_HOLD, IDLE, SETUP, STROBE, HOLD, RECOVER.
- RST_HOLD:
  - rst_n = 0 for RST_CYC cycles, then IDLE with rst_n = 1.
  - No grants are issued.
- IDLE:
  - If any req is high, arbitrate, latch we/addr/wdata and the winner index, then go to SETUP.
  - Else, if an sw_rst is pending, go to RST_HOLD.
- Arbitration (round-robin):
  - Single requester wins.
  - When both request, the master not in last_grant wins; last_grant updates on grant.
  - After reset, m0 wins the first tie.
- SETUP (SETUP_CYC cycles): cs_n = 0, addr driven; oe = 1 and data_out = wdata on writes.
- STROBE (STROBE_CYC cycles):
  - rd_n = 0 on reads, wr_n = 0 on writes.
  - hpi_data_in is captured into a holding register on the last STROBE cycle.
- HOLD (HOLD_CYC cycles):
  - Strobes high; cs_n, addr and data are held.
  - On the last HOLD cycle the winner's ack = 1, and for reads the winner's rdata = captured value.
- RECOVER (RECOVER_CYC cycles): cs_n = 1, oe = 0, then IDLE.
- Latency: req seen in IDLE at cycle 0 → ack at cycle SETUP_CYC+STROBE_CYC+HOLD_CYC (6 with defaults).
- Back-to-back: ack-to-ack spacing is SETUP+STROBE+HOLD+RECOVER+1 (9 with defaults).
- Boundary conditions:
  - req dropped before grant: withdrawn, no ack.
  - req dropped after grant: the access completes and ack still pulses.
  - sw_rst during an access: latched as pending and taken after RECOVER, ahead of any waiting request.
  - sw_rst during RST_HOLD: restarts the counter.
  - Reset asserted mid-access: aborts immediately with no ack; strobes go inactive asynchronously.
  - The non-winning master never sees an ack; its rdata is unchanged.
- Counters are sized by $clog2 of the largest parameter and never wrap (reloaded on state entry).

Decomposition:
- hpi_pkg:
  - state enum hpi_state_t.
  - Register constants: HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3.
- Sub-module hpi_rr_arbiter: 2-way round-robin with last_grant register and a grant-enable input.

Test Plan:
- Release Reset → hpi_rst_n low exactly 16 cycles, then high; busy falls the cycle after; cs_n stays 1 throughout.
- m0 write: addr=2, wdata=16'h1234 → cs_n low cycles 1–6; wr_n low cycles 2–5; oe=1 cycles 1–6 with data_out=16'h1234; m0_ack pulse at cycle 6; rd_n never low.
- m1 read: addr=0, hpi_data_in=16'hBEEF during STROBE → rd_n low 4 cycles; m1_rdata=16'hBEEF with m1_ack at cycle 6; m0_rdata unchanged.
- m0 and m1 request together continuously after reset → grants alternate m0, m1, m0; acks spaced 9 cycles apart.
- sw_rst pulsed during STROBE of an m0 write → write completes with ack; then RST_HOLD for 16 cycles; pending m1 req is granted only afterwards.
- Reset asserted during STROBE → strobes return high immediately, no ack, hpi_rst_n=0; m0 req held → re-serviced after the reset pulse.
